// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared types and constants for the registered 1:2 demultiplexer.
//   lane_state_e : per-lane holding-register state
//   LANE0/LANE1  : select encodings for the two output lanes
//   COUNT_W      : width of the optional delivered-word counters
//                  (present only when DEMUX_COUNT_EN is defined)
// ----------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    localparam logic LANE0   = 1'b0;
    localparam logic LANE1   = 1'b1;
    localparam int   COUNT_W = 16;

endpackage

// File: rtl/demux_lane.sv
// ----------------------------------------------------------------------------
// demux_lane
// One-entry register slice for a single output lane of the demultiplexer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   enable_i   : block enable; low freezes state, register and counter
//   load_i     : a word is accepted into this lane this cycle
//   data_i     : word to capture on load
//   ready_i    : consumer takes the lane word this cycle
//   full_o     : lane holds a word (unmasked by enable)
//   drain_o    : lane word is delivered this cycle
//   data_o     : raw holding register (masking is done by the top)
//   count_o    : delivered-word counter, wraps at 2^COUNT_W
//                (only when DEMUX_COUNT_EN is defined)
// ----------------------------------------------------------------------------
module demux_lane
    import demux_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable_i,
    input  logic         load_i,
    input  logic [N-1:0] data_i,
    input  logic         ready_i,
    output logic         full_o,
    output logic         drain_o,
    output logic [N-1:0] data_o
`ifdef DEMUX_COUNT_EN
    ,
    output logic [COUNT_W-1:0] count_o
`endif
);

    lane_state_e  state_q, state_d;
    logic [N-1:0] data_q, data_d;

    // A drain needs the visible valid, which is gated by enable, so nothing
    // moves while the block is disabled.
    assign drain_o = enable_i && (state_q == LANE_FULL) && ready_i;
    assign full_o  = (state_q == LANE_FULL);
    assign data_o  = data_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            data_d = data_i;
        end
        case (state_q)
            LANE_EMPTY: if (load_i)              state_d = LANE_FULL;
            LANE_FULL:  if (drain_o && !load_i)  state_d = LANE_EMPTY;
            default:                             state_d = LANE_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LANE_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (drain_o) begin
            count_d = count_q + 1'b1;   // natural wrap 0xFFFF -> 0x0000
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;
`endif

endmodule

// File: rtl/demux_1nto2n.sv
// ----------------------------------------------------------------------------
// demux_1nto2n
// Registered 1:2 demultiplexer with valid/ready handshaking. The word on I is
// steered by S into one of two one-entry lanes; each lane's back-pressure is
// independent of the other.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   enable                : low stalls acceptance and masks all lane outputs
//   I, S, in_valid        : producer word, lane select, producer valid
//   in_ready              : word on I/S is accepted this cycle
//   O0/O1                 : lane data (0 when the lane valid is low)
//   O0_valid/O1_valid     : lane holds a word
//   O0_ready/O1_ready     : consumer takes the lane word
//   count0/count1         : delivered-word counters (DEMUX_COUNT_EN only)
// Build option: define DEMUX_COUNT_EN to add the per-lane counters.
// ----------------------------------------------------------------------------
module demux_1nto2n
    import demux_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [N-1:0] I,
    input  logic         S,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] O0,
    output logic [N-1:0] O1,
    output logic         O0_valid,
    output logic         O1_valid,
    input  logic         O0_ready,
    input  logic         O1_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [COUNT_W-1:0] count0,
    output logic [COUNT_W-1:0] count1
`endif
);

    logic         full0, full1, drain0, drain1, load0, load1, accept;
    logic [N-1:0] data0, data1;

    // in_ready looks only at the selected lane and never at in_valid; a full
    // lane can still take a word when it drains on the same edge. Held low
    // during reset so every output reads 0 while rst is asserted.
    assign in_ready = enable && !rst &&
                      ((S == LANE1) ? (!full1 || drain1) : (!full0 || drain0));
    assign accept   = in_valid && in_ready;
    assign load0    = accept && (S == LANE0);
    assign load1    = accept && (S == LANE1);

    assign O0_valid = enable && full0;
    assign O1_valid = enable && full1;
    assign O0       = O0_valid ? data0 : '0;
    assign O1       = O1_valid ? data1 : '0;

    demux_lane #(.N(N)) u_lane0 (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable),
        .load_i   (load0),
        .data_i   (I),
        .ready_i  (O0_ready),
        .full_o   (full0),
        .drain_o  (drain0),
        .data_o   (data0)
`ifdef DEMUX_COUNT_EN
        ,
        .count_o  (count0)
`endif
    );

    demux_lane #(.N(N)) u_lane1 (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable),
        .load_i   (load1),
        .data_i   (I),
        .ready_i  (O1_ready),
        .full_o   (full1),
        .drain_o  (drain1),
        .data_o   (data1)
`ifdef DEMUX_COUNT_EN
        ,
        .count_o  (count1)
`endif
    );

endmodule

// File: tb/tb_demux_1nto2n.sv
// ----------------------------------------------------------------------------
// tb_demux_1nto2n
// Directed bench for demux_1nto2n. A queue-per-lane model tracks what each
// lane must hold; a negedge process compares every output each cycle, and
// directed steps add hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_demux_1nto2n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] I = '0;
    logic        S = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] O0, O1;
    logic        O0_valid, O1_valid;
    logic        O0_ready = 1'b0;
    logic        O1_ready = 1'b0;
`ifdef DEMUX_COUNT_EN
    logic [15:0] count0, count1;
`endif

    int total = 0;
    int bad   = 0;

    demux_1nto2n #(.N(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .I        (I),
        .S        (S),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .O0       (O0),
        .O1       (O1),
        .O0_valid (O0_valid),
        .O1_valid (O1_valid),
        .O0_ready (O0_ready),
        .O1_ready (O1_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .count0   (count0),
        .count1   (count1)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    int          mc0 = 0;
    int          mc1 = 0;

    function automatic bit m_in_ready();
        bit room0, room1;
        room0 = (mq0.size() == 0) || O0_ready;
        room1 = (mq1.size() == 0) || O1_ready;
        return !rst && enable && (S ? room1 : room0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq0.delete();
            mq1.delete();
            mc0 = 0;
            mc1 = 0;
        end else if (enable) begin
            bit acc;
            acc = in_valid && m_in_ready();
            if (mq0.size() > 0 && O0_ready) begin
                void'(mq0.pop_front());
                mc0 = (mc0 + 1) % 65536;
            end
            if (mq1.size() > 0 && O1_ready) begin
                void'(mq1.pop_front());
                mc1 = (mc1 + 1) % 65536;
            end
            if (acc) begin
                if (S) mq1.push_back(I);
                else   mq0.push_back(I);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit          v0, v1;
        logic [31:0] e0, e1;
        v0 = enable && (mq0.size() > 0);
        v1 = enable && (mq1.size() > 0);
        e0 = v0 ? mq0[0] : 32'h0;
        e1 = v1 ? mq1[0] : 32'h0;
        chk("cyc_in_ready", {31'b0, in_ready}, {31'b0, m_in_ready()});
        chk("cyc_O0_valid", {31'b0, O0_valid}, {31'b0, v0});
        chk("cyc_O1_valid", {31'b0, O1_valid}, {31'b0, v1});
        chk("cyc_O0", O0, e0);
        chk("cyc_O1", O1, e1);
`ifdef DEMUX_COUNT_EN
        chk("cyc_count0", {16'b0, count0}, mc0[31:0]);
        chk("cyc_count1", {16'b0, count1}, mc1[31:0]);
`endif
    end

    // drive inputs just after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] w [4];

    initial begin
        w[0] = 32'h11110001; w[1] = 32'h22220002;
        w[2] = 32'h33330003; w[3] = 32'h44440004;

        // reset state
        step();
        step();
        chk("rst_O0", O0, 32'h0);
        chk("rst_O1", O1, 32'h0);
        chk("rst_valids", {30'b0, O0_valid, O1_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        rst = 1'b0;
        step();
        enable = 1'b1;
        #1;
        chk("en_in_ready", {31'b0, in_ready}, 32'h1);
        chk("en_valids", {30'b0, O0_valid, O1_valid}, 32'h0);

        // single word into lane 1
        S = 1'b1; I = 32'hAA000004; in_valid = 1'b1; O1_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("l1_valid", {31'b0, O1_valid}, 32'h1);
        chk("l1_data", O1, 32'hAA000004);
        chk("l1_O0_valid", {31'b0, O0_valid}, 32'h0);
        chk("l1_O0", O0, 32'h0);
        step();
        chk("l1_drained", {31'b0, O1_valid}, 32'h0);

        // lane 0 fills and back-pressures; lane 1 still open
        S = 1'b0; I = 32'hE3A00000; in_valid = 1'b1; O0_ready = 1'b0;
        step();
        I = 32'h0BAD0BAD;
        #1;
        chk("full_in_ready_s0", {31'b0, in_ready}, 32'h0);
        S = 1'b1;
        #1;
        chk("other_in_ready_s1", {31'b0, in_ready}, 32'h1);
        in_valid = 1'b0; S = 1'b0;
        chk("full_hold", O0, 32'hE3A00000);
        step();
        chk("full_hold2", O0, 32'hE3A00000);

        // streaming 4 words through lane 0 at one per cycle
        O0_ready = 1'b1; in_valid = 1'b1; S = 1'b0;
        for (int k = 0; k < 4; k++) begin
            I = w[k];
            #1;
            chk("stream_in_ready", {31'b0, in_ready}, 32'h1);
            step();
            chk("stream_order", O0, w[k]);
        end
        in_valid = 1'b0;
        step();
        chk("stream_empty", {31'b0, O0_valid}, 32'h0);

        // enable masking holds lane 1
        O1_ready = 1'b0; S = 1'b1; I = 32'hE59F1020; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        enable = 1'b0;
        #1;
        chk("dis_O1", O1, 32'h0);
        chk("dis_O1_valid", {31'b0, O1_valid}, 32'h0);
        chk("dis_in_ready", {31'b0, in_ready}, 32'h0);
        O1_ready = 1'b1;
        step();
        step();
        O1_ready = 1'b0;
        enable = 1'b1;
        #1;
        chk("reen_O1", O1, 32'hE59F1020);
        chk("reen_O1_valid", {31'b0, O1_valid}, 32'h1);
        O1_ready = 1'b1;
        step();
        chk("reen_drained", {31'b0, O1_valid}, 32'h0);

        // reset mid-transfer discards the held word
        O0_ready = 1'b0; S = 1'b0; I = 32'h5A5A5A5A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mid_loaded", O0, 32'h5A5A5A5A);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, O0_valid}, 32'h0);
        step();
        rst = 1'b0;
        O0_ready = 1'b1;
        step();
        step();
        chk("post_rst_quiet", {30'b0, O0_valid, O1_valid}, 32'h0);

`ifdef DEMUX_COUNT_EN
        // 65536 lane-0 drains wrap count0 back to zero
        chk("cnt_start", {16'b0, count0}, 32'h0);
        O0_ready = 1'b1; S = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 65537; k++) begin
            I = k;
            step();
        end
        chk("cnt_wrap", {16'b0, count0}, 32'h0);
        in_valid = 1'b0;
        step();
        chk("cnt_one", {16'b0, count0}, 32'h1);
        // reset mid-stream clears both counters
        in_valid = 1'b1; S = 1'b1; O1_ready = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("cnt_rst0", {16'b0, count0}, 32'h0);
        chk("cnt_rst1", {16'b0, count1}, 32'h0);
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1nto2n.md
# demux_1Nto2N

Registered 1:2 demultiplexer for N-bit words with valid/ready handshaking: one input stream is steered by select `S` into one of two output lanes, each backed by a one-entry holding register. It is the distribution counterpart to the 2:1 selector `mux_2NtoN`. It sits between a single producer, such as a decode or fetch stage, and two independent consumers. Each lane provides ordered, lossless delivery, and each lane's back-pressure is isolated from the other lane.

## Interface
- N, 32, data width in bits
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  block enable; low stalls acceptance and masks outputs
- I  input  N  input data word
- S  input  1  lane select: 0 → lane 0, 1 → lane 1
- in_valid  input  1  producer has a word on I/S
- in_ready  output  1  block accepts the word this cycle
- O0, O1  output  N  lane data; reads 0 whenever the lane's valid is low
- O0_valid, O1_valid  output  1  lane holds a word
- O0_ready, O1_ready  input  1  consumer takes the lane word this cycle
- count0, count1  output  16  per-lane delivered-word counters (only with DEMUX_COUNT_EN)

## Operation
- Each lane is a two-state FSM:
  - EMPTY → FULL on load.
  - FULL → EMPTY on drain without a load.
  - FULL → FULL on drain with a simultaneous load.
- Load condition for lane S: in_valid && in_ready.
- Drain condition for lane k: Ok_valid && Ok_ready.
- in_ready = enable && (lane S is EMPTY || lane S drains this cycle). It is combinational from S, enable and the selected lane's state/ready.
- The non-selected lane is unaffected by I/S. It can drain in the same cycle the other lane loads.
- Ok_valid = enable && (lane k FULL). Ok = Ok_valid ? register : 0.
- enable low:
  - in_ready = 0.
  - All valids and data outputs read 0.
  - Lane registers and states are held unchanged, so no word is lost. Delivery resumes the cycle enable returns high.
- Ordering: words within one lane are delivered in acceptance order. No ordering guarantee applies between lanes.
- No data transformation; words pass through bit-exact.

## Timing
- Reset (async assert): both lanes EMPTY, registers 0. All outputs read 0, including in_ready and counters.
- Latency: a word accepted at edge t appears as Ok_valid at the output after edge t (1 cycle).
- Throughput: 1 word/cycle into a lane while its consumer holds ready high (drain+load in the same cycle).
- in_ready must not depend on in_valid.
- Full lane with ready low: in_ready = 0 for S = k until a drain occurs.
- Reset mid-transfer: any held word is discarded. No output pulses after rst deasserts until a new load.

## Configuration
- DEMUX_COUNT_EN defined:
  - count0/count1 ports exist.
  - Each counter increments on its lane's drain and wraps from 0xFFFF to 0x0000.
  - Counters clear on rst and hold while enable is low.
- Undefined: the counter ports and their logic are absent. All other behaviour is identical.

## Structure
- Package demux_pkg holds:
  - lane state enum {LANE_EMPTY, LANE_FULL}
  - LANE0 = 0 and LANE1 = 1
  - COUNT_W = 16
- Sub-module demux_lane (one-entry register slice with state FSM, load/drain logic and optional counter) is instantiated twice. The top level contains only select decode, in_ready and output masking.

## Test plan
- Reset → O0 = O1 = 0, both valids 0, in_ready = 0 (enable = 0). With enable = 1: in_ready = 1, valids 0.
- enable = 1, S = 1, I = 32'hAA000004, in_valid pulse, O1_ready = 1 → next cycle O1_valid = 1, O1 = 32'hAA000004; O0_valid = 0, O0 = 0.
- S = 0, I = 32'hE3A00000, O0_ready = 0 → lane 0 fills. A second S = 0 word sees in_ready = 0, while an S = 1 word in the same cycle sees in_ready = 1.
- Lane 0 full with O0_ready = 1 and in_valid streaming 4 words on S = 0 → one word delivered per cycle, in order, with in_ready held high.
- Lane 1 full (32'hE59F1020), then enable = 0 → O1 = 0, O1_valid = 0, in_ready = 0. With enable = 1 again: O1 = 32'hE59F1020 and valid returns.
- DEMUX_COUNT_EN: preload traffic to 65 536 lane-0 drains → count0 returns to 0. After rst asserted mid-stream, count0 = count1 = 0.
